letter_sequencer: RTL and testbench
===================================

LETTER_SEQUENCER -- requirements
Module: letter_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000: number of clk cycles per letter step in auto mode; legal range >= 2.
REQ-002 Parameter MSG_LEN, default 7: number of letter indices (0..MSG_LEN-1) per message; legal range 1..15.
REQ-003 Parameter GAP_STEPS, default 2: number of blank steps between message repetitions; used only with SEQ_GAP_EN.
REQ-004 Port clk, input, 1: the single clock; all logic is clocked on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port en, input, 1: run enable; low pauses the sequence.
REQ-007 Port mode, input, 1: 0 = auto-advance on the internal tick, 1 = manual advance on step.
REQ-008 Port step, input, 1: single-cycle advance pulse, used only when mode=1.
REQ-009 Port digit, output, 4: letter index fed to the downstream seg7 decoder; 4'hF = blank.
REQ-010 Port msg_done, output, 1: one-cycle pulse on the advance that completes index MSG_LEN-1.
REQ-011 Port running, output, 1: high while the state is SHOW or GAP.

Function
REQ-012 States: IDLE, SHOW, PAUSE, GAP; encoding is free.
REQ-013 IDLE: digit=4'hF, idx=0, prescaler=0; en=1 -> SHOW on the next cycle with digit=0.
REQ-014 "adv" = (mode ? step : tick) & en; "tick" is high for one cycle when prescaler = TICK_DIV-1, after which the prescaler wraps to 0.
REQ-015 The prescaler counts only in SHOW or GAP with mode=0 and en=1; otherwise it holds its value.
REQ-016 SHOW: digit = idx (registered, 1-cycle latency from an idx change); on adv with idx<MSG_LEN-1, idx increments.
REQ-017 SHOW on adv with idx=MSG_LEN-1:
  - msg_done pulses in the same cycle as adv.
  - idx goes to 0.
  - Next state is GAP (SEQ_GAP_EN defined) or SHOW with digit=0 (SEQ_GAP_EN undefined).
REQ-018 GAP: digit=4'hF, gap counter counts adv events; after GAP_STEPS adv events -> SHOW with digit=0.
REQ-019 en falling in SHOW or GAP -> PAUSE: idx, gap counter, prescaler and digit all hold.
REQ-020 PAUSE: en=1 -> return to the exact pre-pause state; the tick resumes from the held prescaler value.
REQ-021 mode may change at any time; it takes effect on the next cycle; the prescaler is not cleared.
REQ-022 Pulses on step when mode=0 or en=0 are ignored; held step in mode=1 advances once per cycle it is high.
REQ-023 All counters wrap with no overflow: idx width is 4, prescaler width is $clog2(TICK_DIV), gap counter width is $clog2(GAP_STEPS+1).

Reset
REQ-024 On rst=1 at a clk edge:
  - state=IDLE, digit=4'hF, idx=0, prescaler=0, gap counter=0.
  - msg_done=0, running=0.
REQ-025 rst overrides all other inputs in the same cycle, including mid-SHOW, mid-GAP and PAUSE.

Configuration
REQ-026 Macro SEQ_GAP_EN, when defined, compiles in the GAP state, the gap counter and the GAP_STEPS parameter usage.
REQ-027 Without SEQ_GAP_EN, the message loops back-to-back and GAP is unreachable and absent.

Structure
REQ-028 Shared package seq_pkg holds:
  - the state enum type;
  - the constant BLANK_DIGIT = 4'hF;
  - the constant DEFAULT_MSG_LEN = 7.
REQ-029 One sub-module, tick_gen, holds the prescaler; ports are clk, rst, run, tick.

Verification
REQ-030 Use TICK_DIV=4, MSG_LEN=7, GAP_STEPS=2 in all scenarios below.
REQ-031 Reset/start: rst for 2 cycles -> digit=F, running=0; en=1 -> digit=0 one cycle later, then 1 after 4 cycles and 2 after 8 cycles.
REQ-032 Wrap: run to idx 6 -> msg_done pulses once, then:
  - with SEQ_GAP_EN: digit=F for 8 cycles, then 0;
  - without SEQ_GAP_EN: digit=0 directly.
REQ-033 Pause: drop en at digit=3 for 10 cycles -> digit stays 3; raise en -> digit=4 after the remaining prescaler count.
REQ-034 Manual mode: mode=1, three single-cycle step pulses from digit=0 -> digit=3; step with en=0 -> digit unchanged.
REQ-035 Mid-run reset: rst asserted during GAP or SHOW -> next cycle digit=F, state IDLE, msg_done=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the letter sequencer and its prescaler.
// The GAP state only exists when SEQ_GAP_EN is defined.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_PAUSE = 2'd2
`ifdef SEQ_GAP_EN
        ,
        ST_GAP   = 2'd3
`endif
    } seq_state_t;

    localparam logic [3:0] BLANK_DIGIT     = 4'hF;
    localparam int         DEFAULT_MSG_LEN = 7;
    localparam int         IDX_W           = 4;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every TICK_DIV cycles of run.
// The count holds whenever run is low, so a paused sequence resumes mid-period.
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int             CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign tick      = run & w_at_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/letter_sequencer.sv
// Steps a letter index 0..MSG_LEN-1 onto digit, automatically or by manual step pulses.
// Define SEQ_GAP_EN to insert GAP_STEPS blank steps between message repetitions.
module letter_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MSG_LEN   = DEFAULT_MSG_LEN,
    parameter int GAP_STEPS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       step,
    output logic [3:0] digit,
    output logic       msg_done,
    output logic       running
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    // Elaboration-time guards on the legal parameter ranges.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("letter_sequencer: TICK_DIV must be >= 2");
    end
    if (MSG_LEN < 1 || MSG_LEN > 15) begin : g_bad_msg_len
        $error("letter_sequencer: MSG_LEN must be in 1..15");
    end
    if (GAP_STEPS < 1) begin : g_bad_gap_steps
        $error("letter_sequencer: GAP_STEPS must be >= 1");
    end

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic [3:0]       r_digit;
    logic [3:0]       w_next_digit;
    logic             w_tick;
    logic             w_run;
    logic             w_adv;
    logic             w_active;

`ifdef SEQ_GAP_EN
    localparam int             GAP_W    = (GAP_STEPS > 1) ? $clog2(GAP_STEPS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_STEPS - 1);

    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_next_gap_cnt;
    logic             r_resume_gap;
    logic             w_next_resume_gap;

    assign w_active = (r_state == ST_SHOW) || (r_state == ST_GAP);
`else
    assign w_active = (r_state == ST_SHOW);
`endif

    assign w_run = w_active & ~mode & en;
    assign w_adv = (mode ? step : w_tick) & en;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_digit      <= BLANK_DIGIT;
`ifdef SEQ_GAP_EN
            r_gap_cnt    <= '0;
            r_resume_gap <= 1'b0;
`endif
        end else begin
            r_state      <= w_next_state;
            r_idx        <= w_next_idx;
            r_digit      <= w_next_digit;
`ifdef SEQ_GAP_EN
            r_gap_cnt    <= w_next_gap_cnt;
            r_resume_gap <= w_next_resume_gap;
`endif
        end
    end

    // NOTE: every signal assigned below gets a hold default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state      = r_state;
        w_next_idx        = r_idx;
        w_next_digit      = r_digit;
`ifdef SEQ_GAP_EN
        w_next_gap_cnt    = r_gap_cnt;
        w_next_resume_gap = r_resume_gap;
`endif
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next_state = ST_SHOW;
                    w_next_idx   = '0;
                    w_next_digit = 4'd0;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    w_next_state      = ST_PAUSE;
`ifdef SEQ_GAP_EN
                    w_next_resume_gap = 1'b0;
`endif
                end else if (w_adv) begin
                    if (r_idx == IDX_LAST) begin
                        w_next_idx = '0;
`ifdef SEQ_GAP_EN
                        w_next_state   = ST_GAP;
                        w_next_gap_cnt = '0;
                        w_next_digit   = BLANK_DIGIT;
`else
                        w_next_digit   = 4'd0;
`endif
                    end else begin
                        w_next_idx   = r_idx + IDX_W'(1);
                        w_next_digit = r_idx + IDX_W'(1);
                    end
                end
            end
`ifdef SEQ_GAP_EN
            ST_GAP: begin
                if (!en) begin
                    w_next_state      = ST_PAUSE;
                    w_next_resume_gap = 1'b1;
                end else if (w_adv) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_next_state   = ST_SHOW;
                        w_next_gap_cnt = '0;
                        w_next_digit   = 4'd0;
                    end else begin
                        w_next_gap_cnt = r_gap_cnt + GAP_W'(1);
                    end
                end
            end
`endif
            ST_PAUSE: begin
                // Everything but the state holds, so resuming is exact.
                if (en) begin
`ifdef SEQ_GAP_EN
                    w_next_state = r_resume_gap ? ST_GAP : ST_SHOW;
`else
                    w_next_state = ST_SHOW;
`endif
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        digit    = r_digit;
        running  = w_active;
        msg_done = (r_state == ST_SHOW) && w_adv && (r_idx == IDX_LAST);
    end

endmodule

// File: tb/tb_letter_sequencer.sv
// Directed bench for letter_sequencer with TICK_DIV=4, MSG_LEN=7, GAP_STEPS=2.
// Expectations follow SEQ_GAP_EN, so the bench pairs with either build of the RTL.
module tb_letter_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int MSG_LEN   = 7;
    localparam int GAP_STEPS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       step;
    logic [3:0] digit;
    logic       msg_done;
    logic       running;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    letter_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .MSG_LEN   (MSG_LEN),
        .GAP_STEPS (GAP_STEPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .step     (step),
        .digit    (digit),
        .msg_done (msg_done),
        .running  (running)
    );

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        step = 1'b0;
        cycles(2);
        rst = 1'b0;
        check("reset_digit", digit, 4'hF);
        check("reset_running", 4'(running), 4'd0);
        check("reset_msg_done", 4'(msg_done), 4'd0);
        cycles(1);
        check("idle_hold_digit", digit, 4'hF);

        // Auto start: 0 one cycle after en, then one letter per 4 cycles.
        en = 1'b1;
        cycles(1);
        check("start_digit", digit, 4'd0);
        check("start_running", 4'(running), 4'd1);
        cycles(3);
        check("pre_tick_digit", digit, 4'd0);
        cycles(1);
        check("tick1_digit", digit, 4'd1);
        cycles(4);
        check("tick2_digit", digit, 4'd2);
        cycles(4);
        check("tick3_digit", digit, 4'd3);

        // Pause with the prescaler at 2; after resume it needs 1 extra cycle to re-enter SHOW.
        cycles(2);
        check("before_pause_digit", digit, 4'd3);
        en = 1'b0;
        cycles(1);
        check("pause_digit", digit, 4'd3);
        check("pause_running", 4'(running), 4'd0);
        cycles(9);
        check("pause_hold_digit", digit, 4'd3);
        en = 1'b1;
        cycles(2);
        check("resume_wait_digit", digit, 4'd3);
        cycles(1);
        check("resume_tick_digit", digit, 4'd4);

        // Wrap from index 6.
        cycles(4);
        check("digit5", digit, 4'd5);
        cycles(4);
        check("digit6", digit, 4'd6);
        cycles(3);
        check("wrap_msg_done", 4'(msg_done), 4'd1);
        check("wrap_digit6", digit, 4'd6);
        cycles(1);
        check("post_wrap_msg_done", 4'(msg_done), 4'd0);
`ifdef SEQ_GAP_EN
        check("gap_digit_first", digit, 4'hF);
        check("gap_running", 4'(running), 4'd1);
        cycles(7);
        check("gap_digit_last", digit, 4'hF);
        cycles(1);
        check("gap_exit_digit", digit, 4'd0);
`else
        check("loop_digit", digit, 4'd0);
        check("loop_running", 4'(running), 4'd1);
`endif

        // Manual mode: three separated single-cycle pulses.
        mode = 1'b1;
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        check("manual_step1", digit, 4'd1);
        cycles(1);
        check("manual_idle", digit, 4'd1);
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(1);
        check("manual_step2", digit, 4'd2);
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        check("manual_step3", digit, 4'd3);
        cycles(5);
        check("manual_no_tick", digit, 4'd3);

        // Step ignored with en low, and in auto mode.
        en   = 1'b0;
        step = 1'b1;
        cycles(1);
        check("step_en_low_digit", digit, 4'd3);
        check("step_en_low_running", 4'(running), 4'd0);
        step = 1'b0;
        en   = 1'b1;
        cycles(1);
        check("manual_resume_digit", digit, 4'd3);
        check("manual_resume_running", 4'(running), 4'd1);
        mode = 1'b0;
        step = 1'b1;
        cycles(1);
        check("step_auto_ignored", digit, 4'd3);

        // Held step in manual mode advances once per cycle.
        mode = 1'b1;
        cycles(2);
        check("held_step_digit", digit, 4'd5);
        cycles(1);
        check("held_step_digit6", digit, 4'd6);
        check("manual_msg_done", 4'(msg_done), 4'd1);
        cycles(1);
        step = 1'b0;
`ifdef SEQ_GAP_EN
        check("manual_gap_digit", digit, 4'hF);
`else
        check("manual_loop_digit", digit, 4'd0);
`endif

        // Reset overrides en and step, from GAP (or SHOW without gaps).
        rst  = 1'b1;
        step = 1'b1;
        cycles(1);
        check("midrun_rst_digit", digit, 4'hF);
        check("midrun_rst_running", 4'(running), 4'd0);
        check("midrun_rst_msg_done", 4'(msg_done), 4'd0);
        cycles(1);
        check("held_rst_digit", digit, 4'hF);
        rst  = 1'b0;
        step = 1'b0;
        mode = 1'b0;
        cycles(1);
        check("restart_digit", digit, 4'd0);
        cycles(4);
        check("restart_tick_digit", digit, 4'd1);

        // Reset mid-SHOW.
        rst = 1'b1;
        cycles(1);
        check("show_rst_digit", digit, 4'hF);
        check("show_rst_running", 4'(running), 4'd0);
        rst = 1'b0;
        en  = 1'b0;
        cycles(2);
        check("post_rst_idle_digit", digit, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
